mkio_tx_encoder: RTL and testbench

- MIL-STD-1553 word transmitter; sits directly downstream of mkio_control.
- Consumes the word handshake (tx_ready, tx_data, tx_cd) and returns tx_busy.
- Serialises each 16-bit word into a 20-bit-time Manchester-II frame: 3-bit-time sync, 16 data bits MSB first, odd parity.
- Drives the bipolar line-driver pair (tx_p/tx_n) plus transmit enable.

---
 rtl/mkio_pkg.sv | 56 +++++
 rtl/mkio_halfbit_timer.sv | 50 +++++
 rtl/mkio_tx_encoder.sv | 161 ++++++++++++++++
 tb/tb_mkio_tx_encoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mkio_pkg.sv
// mkio_pkg: shared definitions for the MIL-STD-1553 transmit path.
//   - frame geometry (sync half-bits, data bits, half-bits per frame)
//   - transmitter FSM state encoding
//   - line-level encodings as {tx_p, tx_n}
//   - parity and half-bit level helper functions
package mkio_pkg;

   localparam int SYNC_HALFBITS  = 6;
   localparam int DATA_BITS      = 16;
   localparam int FRAME_HALFBITS = 40;

   // Last half-bit index of each frame section
   localparam logic [5:0] SYNC_LAST_HB = 6'(SYNC_HALFBITS - 1);
   localparam logic [5:0] BITS_LAST_HB = 6'(SYNC_HALFBITS + 2 * DATA_BITS - 1);
   localparam logic [5:0] PAR_LAST_HB  = 6'(FRAME_HALFBITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      BITS = 2'd2,
      PAR  = 2'd3
   } tx_state_t;

   // Line levels as {tx_p, tx_n}; both high is never driven
   localparam logic [1:0] LINE_HIGH = 2'b10;
   localparam logic [1:0] LINE_LOW  = 2'b01;
   localparam logic [1:0] LINE_IDLE = 2'b00;

   // Odd parity bit: data plus parity always holds an odd number of ones
   function automatic logic odd_parity(input logic [15:0] data);
      return ~(^data);
   endfunction

   // Line level for half-bit idx of a frame carrying data/cd/par.
   // Data and parity half-bits start on even indices, so idx[0] selects
   // the second (inverted) half of the Manchester-II cell.
   function automatic logic [1:0] halfbit_level(input logic [5:0]  idx,
                                                input logic [15:0] data,
                                                input logic        cd,
                                                input logic        par);
      logic        lvl;
      logic [16:0] mask;
      lvl  = 1'b0;
      mask = 17'd0;
      if (idx < 6'(SYNC_HALFBITS)) begin
         // command/status sync is high-then-low, data sync is the inverse
         lvl = (idx < 6'd3) ? ~cd : cd;
      end else begin
         // bit k of the 17-bit {data, par} word, k = 0 being data[15]
         mask = 17'h1_0000 >> ((idx - 6'(SYNC_HALFBITS)) >> 1);
         lvl  = (|({data, par} & mask)) ^ idx[0];
      end
      return lvl ? LINE_HIGH : LINE_LOW;
   endfunction

endpackage

// File: rtl/mkio_halfbit_timer.sv
// mkio_halfbit_timer: half-bit prescaler for the 1553 transmitter.
//   clk     in   system clock
//   reset   in   synchronous active-high reset
//   restart in   start a new frame: prescaler and index go to 0
//   enable  in   advance while a frame is on the line
//   tick    out  current cycle is the last one of the current half-bit
//   index   out  half-bit index within the frame (0..39)
module mkio_halfbit_timer #(
   parameter int CLK_PER_HALFBIT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       restart,
   input  logic       enable,
   output logic       tick,
   output logic [5:0] index
);

   localparam int CW = (CLK_PER_HALFBIT > 2) ? $clog2(CLK_PER_HALFBIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_HALFBIT - 1);

   logic [CW-1:0] cnt_r;
   logic [5:0]    index_r;

   // Half-bit boundary flag
   always_comb begin
      tick = (cnt_r == CNT_LAST);
   end

   assign index = index_r;

   // Prescaler and half-bit index counters
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r   <= '0;
         index_r <= 6'd0;
      end else if (restart) begin
         cnt_r   <= '0;
         index_r <= 6'd0;
      end else if (enable) begin
         if (tick) begin
            cnt_r   <= '0;
            index_r <= index_r + 6'd1;
         end else begin
            cnt_r   <= cnt_r + CW'(1);
         end
      end
   end

endmodule

// File: rtl/mkio_tx_encoder.sv
// mkio_tx_encoder: MIL-STD-1553 word transmitter (Manchester-II).
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   tx_ready  in   one-cycle strobe requesting transmission of tx_data/tx_cd
//   tx_data   in   16-bit word, bit 15 sent first
//   tx_cd     in   0 = command/status sync, 1 = data sync
//   tx_busy   out  word on the line or pending
//   tx_p      out  positive line drive
//   tx_n      out  negative line drive
//   tx_en     out  line-driver enable
//   word_done out  one-cycle pulse after a word's final half-bit
//   overrun   out  one-cycle pulse when a strobe is dropped
// Each word is a 40 half-bit frame; a one-deep pending buffer lets the
// next word follow with no dead cycle.
module mkio_tx_encoder #(
   parameter int CLK_PER_HALFBIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_ready,
   input  logic [15:0] tx_data,
   input  logic        tx_cd,
   output logic        tx_busy,
   output logic        tx_p,
   output logic        tx_n,
   output logic        tx_en,
   output logic        word_done,
   output logic        overrun
);
   import mkio_pkg::*;

   tx_state_t   state_r;
   logic [15:0] act_data_r;
   logic        act_cd_r;
   logic        act_par_r;
   logic [15:0] pend_data_r;
   logic        pend_cd_r;
   logic        pend_valid_r;
   logic        tx_busy_r, tx_p_r, tx_n_r, tx_en_r, word_done_r, overrun_r;

   logic        tick_s;
   logic [5:0]  index_s;

   logic        frame_end_s, start_idle_s, chain_pend_s, chain_bypass_s;
   logic        restart_s, overrun_s, latch_pend_s, next_pend_valid_s;
   logic [5:0]  next_index_s;
   tx_state_t   next_state_s;
   logic [15:0] next_data_s;
   logic        next_cd_s, next_par_s;
   logic [1:0]  next_line_s;

   mkio_halfbit_timer #(
      .CLK_PER_HALFBIT(CLK_PER_HALFBIT)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .restart(restart_s),
      .enable (state_r != IDLE),
      .tick   (tick_s),
      .index  (index_s)
   );

   // Word-start, buffer and next-state decisions
   always_comb begin
      frame_end_s    = (state_r == PAR) && tick_s && (index_s == PAR_LAST_HB);
      start_idle_s   = (state_r == IDLE) && tx_ready;
      chain_pend_s   = frame_end_s && pend_valid_r;
      // a strobe landing on the frame's last cycle goes straight out next
      chain_bypass_s = frame_end_s && !pend_valid_r && tx_ready;
      restart_s      = start_idle_s || chain_pend_s || chain_bypass_s;
      overrun_s      = (state_r != IDLE) && tx_ready && pend_valid_r;
      latch_pend_s   = (state_r != IDLE) && tx_ready && !pend_valid_r && !frame_end_s;

      if (chain_pend_s) begin
         next_data_s = pend_data_r;
         next_cd_s   = pend_cd_r;
      end else begin
         next_data_s = tx_data;
         next_cd_s   = tx_cd;
      end
      next_par_s = odd_parity(next_data_s);

      if (chain_pend_s) begin
         next_pend_valid_s = 1'b0;
      end else if (latch_pend_s) begin
         next_pend_valid_s = 1'b1;
      end else begin
         next_pend_valid_s = pend_valid_r;
      end

      if (restart_s) begin
         next_index_s = 6'd0;
      end else if (tick_s && (state_r != IDLE)) begin
         next_index_s = index_s + 6'd1;
      end else begin
         next_index_s = index_s;
      end

      case (state_r)
         IDLE:    next_state_s = tx_ready ? SYNC : IDLE;
         SYNC:    next_state_s = (tick_s && (index_s == SYNC_LAST_HB)) ? BITS : SYNC;
         BITS:    next_state_s = (tick_s && (index_s == BITS_LAST_HB)) ? PAR : BITS;
         PAR:     next_state_s = frame_end_s ? (restart_s ? SYNC : IDLE) : PAR;
         default: next_state_s = IDLE;
      endcase

      // registered line level is the one for the half-bit of the next cycle
      if (next_state_s == IDLE) begin
         next_line_s = LINE_IDLE;
      end else if (restart_s) begin
         next_line_s = halfbit_level(next_index_s, next_data_s, next_cd_s, next_par_s);
      end else begin
         next_line_s = halfbit_level(next_index_s, act_data_r, act_cd_r, act_par_r);
      end
   end

   // Transmitter FSM, word registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         act_data_r   <= 16'd0;
         act_cd_r     <= 1'b0;
         act_par_r    <= 1'b0;
         pend_data_r  <= 16'd0;
         pend_cd_r    <= 1'b0;
         pend_valid_r <= 1'b0;
         tx_busy_r    <= 1'b0;
         tx_p_r       <= 1'b0;
         tx_n_r       <= 1'b0;
         tx_en_r      <= 1'b0;
         word_done_r  <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if (restart_s) begin
            act_data_r <= next_data_s;
            act_cd_r   <= next_cd_s;
            act_par_r  <= next_par_s;
         end
         if (latch_pend_s) begin
            pend_data_r <= tx_data;
            pend_cd_r   <= tx_cd;
         end
         pend_valid_r <= next_pend_valid_s;
         tx_busy_r    <= (next_state_s != IDLE) || next_pend_valid_s;
         tx_p_r       <= next_line_s[1];
         tx_n_r       <= next_line_s[0];
         tx_en_r      <= (next_state_s != IDLE);
         word_done_r  <= frame_end_s;
         overrun_r    <= overrun_s;
      end
   end

   assign tx_busy   = tx_busy_r;
   assign tx_p      = tx_p_r;
   assign tx_n      = tx_n_r;
   assign tx_en     = tx_en_r;
   assign word_done = word_done_r;
   assign overrun   = overrun_r;

endmodule

// File: tb/tb_mkio_tx_encoder.sv
// tb_mkio_tx_encoder: directed bench for mkio_tx_encoder (CLK_PER_HALFBIT=8).
// Each scenario fills per-cycle stimulus and expected-output tables, then a
// runner drives and compares every cycle. Cycle 0 is the strobe cycle.
module tb_mkio_tx_encoder;

   localparam int HB       = 8;
   localparam int WORD_CYC = 40 * HB;
   localparam int MAXC     = 1000;
   localparam logic [1:0] LH = 2'b10;
   localparam logic [1:0] LL = 2'b01;

   logic        clk = 1'b0;
   logic        reset;
   logic        tx_ready;
   logic [15:0] tx_data;
   logic        tx_cd;
   logic        tx_busy, tx_p, tx_n, tx_en, word_done, overrun;

   int n_checks = 0;
   int n_fail   = 0;

   logic        st_ready [MAXC];
   logic [15:0] st_data  [MAXC];
   logic        st_cd    [MAXC];
   logic        st_reset [MAXC];
   logic [1:0]  ex_line  [MAXC];
   logic        ex_en    [MAXC];
   logic        ex_busy  [MAXC];
   logic        ex_done  [MAXC];
   logic        ex_ovr   [MAXC];

   typedef struct {
      logic        cd;
      logic [15:0] data;
      logic        par;
   } vec_t;

   vec_t vecs[6];

   mkio_tx_encoder #(.CLK_PER_HALFBIT(HB)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_cd    (tx_cd),
      .tx_busy  (tx_busy),
      .tx_p     (tx_p),
      .tx_n     (tx_n),
      .tx_en    (tx_en),
      .word_done(word_done),
      .overrun  (overrun)
   );

   // 10 ns system clock
   always #5 clk = ~clk;

   task automatic clear_scn();
      for (int c = 0; c < MAXC; c++) begin
         st_ready[c] = 1'b0;
         st_data[c]  = 16'd0;
         st_cd[c]    = 1'b0;
         st_reset[c] = 1'b0;
         ex_line[c]  = 2'b00;
         ex_en[c]    = 1'b0;
         ex_busy[c]  = 1'b0;
         ex_done[c]  = 1'b0;
         ex_ovr[c]   = 1'b0;
      end
   endtask

   task automatic add_strobe(input int c, input logic cd, input logic [15:0] d);
      st_ready[c] = 1'b1;
      st_data[c]  = d;
      st_cd[c]    = cd;
   endtask

   // Expected line for a word whose first half-bit is driven in cycle s;
   // ncyc < WORD_CYC models a frame cut short by reset.
   task automatic add_word(input int s, input logic cd, input logic [15:0] d,
                           input logic par, input int ncyc);
      logic [1:0] hb[$];
      for (int i = 0; i < 3; i++) hb.push_back(cd ? LL : LH);
      for (int i = 0; i < 3; i++) hb.push_back(cd ? LH : LL);
      for (int b = 15; b >= 0; b--) begin
         hb.push_back(d[b] ? LH : LL);
         hb.push_back(d[b] ? LL : LH);
      end
      hb.push_back(par ? LH : LL);
      hb.push_back(par ? LL : LH);
      for (int c = 0; c < ncyc; c++) begin
         ex_line[s + c] = hb[c / HB];
         ex_en[s + c]   = 1'b1;
         ex_busy[s + c] = 1'b1;
      end
      if (ncyc == WORD_CYC) ex_done[s + WORD_CYC] = 1'b1;
   endtask

   task automatic run_scn(input string name, input int len);
      logic [5:0] got;
      logic [5:0] exp;
      for (int c = 0; c < len; c++) begin
         reset    = st_reset[c];
         tx_ready = st_ready[c];
         tx_data  = st_data[c];
         tx_cd    = st_cd[c];
         #3;
         got = {tx_p, tx_n, tx_en, tx_busy, word_done, overrun};
         exp = {ex_line[c], ex_en[c], ex_busy[c], ex_done[c], ex_ovr[c]};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
               $display("FAIL %s cycle %0d: {p,n,en,busy,done,ovr} got %b expected %b",
                        name, c, got, exp);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Stimulus and checking
   initial begin
      vecs[0] = '{cd: 1'b0, data: 16'h0823, par: 1'b1};
      vecs[1] = '{cd: 1'b1, data: 16'hFFFF, par: 1'b1};
      vecs[2] = '{cd: 1'b0, data: 16'h0001, par: 1'b0};
      vecs[3] = '{cd: 1'b1, data: 16'h0000, par: 1'b1};
      vecs[4] = '{cd: 1'b1, data: 16'h0007, par: 1'b0};
      vecs[5] = '{cd: 1'b0, data: 16'hA5A5, par: 1'b1};

      reset    = 1'b1;
      tx_ready = 1'b0;
      tx_data  = 16'd0;
      tx_cd    = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      n_checks++;
      if ({tx_p, tx_n, tx_en, tx_busy, word_done, overrun} !== 6'b000000) begin
         n_fail++;
         $display("FAIL reset_state: got %b expected 000000",
                  {tx_p, tx_n, tx_en, tx_busy, word_done, overrun});
      end
      reset = 1'b0;
      @(posedge clk);
      #1;

      // single words from the table
      for (int v = 0; v < 6; v++) begin
         clear_scn();
         add_strobe(0, vecs[v].cd, vecs[v].data);
         add_word(1, vecs[v].cd, vecs[v].data, vecs[v].par, WORD_CYC);
         run_scn($sformatf("single_%0d", v), WORD_CYC + 5);
      end

      // second strobe mid-frame: contiguous second word
      clear_scn();
      add_strobe(0, 1'b0, 16'h0823);
      add_strobe(100, 1'b1, 16'hA5A5);
      add_word(1, 1'b0, 16'h0823, 1'b1, WORD_CYC);
      add_word(1 + WORD_CYC, 1'b1, 16'hA5A5, 1'b1, WORD_CYC);
      run_scn("back_to_back", 2 * WORD_CYC + 5);

      // strobe on the frame's last cycle with pending empty
      clear_scn();
      add_strobe(0, 1'b1, 16'h1234);
      add_strobe(WORD_CYC, 1'b0, 16'h8000);
      add_word(1, 1'b1, 16'h1234, 1'b0, WORD_CYC);
      add_word(1 + WORD_CYC, 1'b0, 16'h8000, 1'b0, WORD_CYC);
      run_scn("par_end_chain", 2 * WORD_CYC + 5);

      // third strobe dropped while pending is full
      clear_scn();
      add_strobe(0, 1'b0, 16'h00FF);
      add_strobe(50, 1'b1, 16'h7FFF);
      add_strobe(60, 1'b0, 16'hDEAD);
      ex_ovr[61] = 1'b1;
      add_word(1, 1'b0, 16'h00FF, 1'b1, WORD_CYC);
      add_word(1 + WORD_CYC, 1'b1, 16'h7FFF, 1'b0, WORD_CYC);
      run_scn("overrun", 2 * WORD_CYC + 10);

      // reset mid-frame with a word pending, then a fresh word
      clear_scn();
      add_strobe(0, 1'b1, 16'h5555);
      add_strobe(50, 1'b0, 16'h3333);
      st_reset[100] = 1'b1;
      add_word(1, 1'b1, 16'h5555, 1'b1, 100);
      add_strobe(110, 1'b0, 16'h0F0F);
      add_word(111, 1'b0, 16'h0F0F, 1'b1, WORD_CYC);
      run_scn("reset_mid_frame", 111 + WORD_CYC + 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
